// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder slice.
package mem_resp_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned DEF_DEPTH         = 256;
    localparam int unsigned DEF_READ_LATENCY  = 2;
    localparam int unsigned DEF_WRITE_LATENCY = 1;
    // Latencies are limited to 1..4, so the down-counter only needs to hold 0..3.
    localparam int unsigned CNT_W             = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word-index width for a given depth, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the control unit and the memory responder.
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              memRead;
    logic              memWrite;
    logic [31:0]       address;
    logic [WORD_W-1:0] writeData;
    logic [WORD_W-1:0] readData;
    logic              memReady;
    logic              memError;

    modport master (
        output memRead, memWrite, address, writeData,
        input  readData, memReady, memError
    );

    modport slave (
        input  memRead, memWrite, address, writeData,
        output readData, memReady, memError
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// DEPTH x WORD_W storage: synchronous write, registered read.
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = idx_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register only changes on a completed read, so it holds between reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable read/write latency.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
    parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
    input  logic           clk,
    input  logic           reset,
    mem_responder_if.slave bus
);

    localparam int unsigned AW = idx_width(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic              err_q, err_d;
    logic              arr_we, arr_re;
    logic              req, bad;
    logic [WORD_W-1:0] arr_rdata;

    assign req = bus.memRead | bus.memWrite;
    assign bad = (bus.memRead & bus.memWrite)
               | (bus.address[1:0] != 2'b00)
               | ({2'b00, bus.address[31:2]} >= DEPTH);

    // State, counter and captured request registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            err_q   <= err_d;
        end
    end

    // Next-state, capture and array strobe decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        err_d   = 1'b0;
        arr_we  = 1'b0;
        arr_re  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad) begin
                        err_d = 1'b1;
                    end else begin
                        idx_d   = bus.address[AW+1:2];
                        wdata_d = bus.writeData;
                        is_wr_d = bus.memWrite;
                        cnt_d   = bus.memWrite ? CNT_W'(WRITE_LATENCY - 1)
                                               : CNT_W'(READ_LATENCY - 1);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // The access fires on the edge that leaves BUSY, so the registered
                // read data and the commit both land as DONE begins.
                if (cnt_q == '0) begin
                    arr_we  = is_wr_q;
                    arr_re  = ~is_wr_q;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (arr_we),
        .re_i    (arr_re),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign bus.readData = arr_rdata;
    assign bus.memReady = (state_q == DONE);
    assign bus.memError = err_q;

endmodule
